ram_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer that shares one single-port RAM between NUM_REQ requesters. The RAM has a combinational read and a clocked write.
- Each requester issues a read or write command with a req/ack handshake.
- The arbiter registers the winning command, drives the RAM port for exactly one cycle, then returns read data with a one-cycle ack pulse.
- It sits between the core/interconnect-side requesters and the RAM instance.

---
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and access sequencer that shares one
// single-port RAM (combinational read, clocked write) between NUM_REQ requesters.
// Each command goes IDLE -> ACCESS (one RAM cycle) -> RESPOND (one-cycle ack).
// Optional feature macro: ARB_LOCK_EN. When it is defined, a requester that
// holds lock high keeps ownership for back-to-back commands.
module ram_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       we,
    input  logic [NUM_REQ*WIDTH-1:0] addr,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    input  logic [NUM_REQ-1:0]       lock,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rdata,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     memory_write_enable,
    output logic [WIDTH-1:0]         address_rw,
    output logic [WIDTH-1:0]         data_in,
    input  logic [WIDTH-1:0]         data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   grant_id_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [WIDTH-1:0]   rdata_q;
    logic               busy_q;
    logic               mwe_q;
    logic [WIDTH-1:0]   addr_q;
    logic [WIDTH-1:0]   wdata_q;

    logic [IDX_W-1:0]   win_d;
    logic               found_d;
    logic               locked_d;
    logic [IDX_W-1:0]   rr_next_d;
    logic [IDX_W-1:0]   cand;
    int unsigned        idx;

    logic [WIDTH-1:0]   addr_a  [NUM_REQ];
    logic [WIDTH-1:0]   wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*WIDTH +: WIDTH];
        assign wdata_a[g] = wdata[g*WIDTH +: WIDTH];
    end

`ifdef ARB_LOCK_EN
    logic lock_valid_q;
    logic skip_adv_q;
`else
    logic lock_unused;
    assign lock_unused = ^lock;
`endif

    // Winner search: first requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        win_d    = grant_id_q;
        found_d  = 1'b0;
        locked_d = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IDX_W'(idx);
            if (!found_d && req[cand]) begin
                found_d = 1'b1;
                win_d   = cand;
            end
        end
`ifdef ARB_LOCK_EN
        if (lock_valid_q && req[grant_id_q]) begin
            found_d  = 1'b1;
            win_d    = grant_id_q;
            locked_d = 1'b1;
        end
`endif
        // Explicit compare keeps the wrap correct for non-power-of-2 NUM_REQ.
        if (grant_id_q == IDX_W'(NUM_REQ - 1)) rr_next_d = '0;
        else                                   rr_next_d = grant_id_q + 1'b1;
    end

    // Sequencer FSM with registered RAM-port and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            mwe_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef ARB_LOCK_EN
            lock_valid_q <= 1'b0;
            skip_adv_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (found_d) begin
                        grant_id_q <= win_d;
                        mwe_q      <= we[win_d];
                        addr_q     <= addr_a[win_d];
                        wdata_q    <= wdata_a[win_d];
                        busy_q     <= 1'b1;
                        state_q    <= ACCESS;
`ifdef ARB_LOCK_EN
                        lock_valid_q <= lock[win_d];
                        skip_adv_q   <= locked_d;
`endif
                    end else begin
`ifdef ARB_LOCK_EN
                        lock_valid_q <= 1'b0;
`endif
                    end
                end
                ACCESS: begin
                    rdata_q <= data_out;
                    mwe_q   <= 1'b0;
                    ack_q   <= NUM_REQ'(1) << grant_id_q;
                    state_q <= RESPOND;
`ifdef ARB_LOCK_EN
                    if (!skip_adv_q) rr_ptr_q <= rr_next_d;
`else
                    rr_ptr_q <= rr_next_d;
`endif
                end
                RESPOND: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    mwe_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack                 = ack_q;
    assign rdata               = rdata_q;
    assign busy                = busy_q;
    assign grant_id            = grant_id_q;
    assign memory_write_enable = mwe_q;
    assign address_rw          = addr_q;
    assign data_in             = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req, we, lock, ack;
    logic [N*W-1:0] addr, wdata;
    logic [W-1:0] rdata, address_rw, data_in, data_out;
    logic         busy, mwe;
    logic [1:0]   grant_id;

    logic [W-1:0] mem [256];
    int passed = 0;
    int total  = 0;
    int nack;

    ram_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .lock(lock), .ack(ack), .rdata(rdata), .busy(busy),
        .grant_id(grant_id), .memory_write_enable(mwe),
        .address_rw(address_rw), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, clocked write.
    assign data_out = mem[address_rw];
    always @(posedge clk) if (mwe) mem[address_rw] <= data_in;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_cmd(input int r, input logic w, input logic [7:0] a, input logic [7:0] d);
        req[r] = 1'b1;
        we[r]  = w;
        addr[r*W +: W]  = a;
        wdata[r*W +: W] = d;
    endtask

    // One complete transaction from an IDLE cycle back to IDLE.
    task automatic single(input int r, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
        logic [3:0] e;
        e = 4'b0001 << r;
        set_cmd(r, w, a, d);
        tick;
        chk({tag, ".busy"},  32'(busy), 1);
        chk({tag, ".mwe"},   32'(mwe), 32'(w));
        chk({tag, ".addr"},  32'(address_rw), 32'(a));
        chk({tag, ".ack0"},  32'(ack), 0);
        chk({tag, ".grant"}, 32'(grant_id), r);
        if (w) chk({tag, ".din"}, 32'(data_in), 32'(d));
        tick;
        chk({tag, ".ack"},   32'(ack), 32'(e));
        chk({tag, ".mweoff"}, 32'(mwe), 0);
        chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
        req[r] = 1'b0;
        tick;
        chk({tag, ".ackclr"}, 32'(ack), 0);
        chk({tag, ".idle"},  32'(busy), 0);
    endtask

    initial begin
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16] = 8'h33;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.ack",   32'(ack), 0);
        chk("rst.rdata", 32'(rdata), 0);
        chk("rst.busy",  32'(busy), 0);
        chk("rst.grant", 32'(grant_id), 0);
        chk("rst.mwe",   32'(mwe), 0);
        chk("rst.addr",  32'(address_rw), 0);
        chk("rst.din",   32'(data_in), 0);
        reset = 1'b0;
        tick;

        // Single write then read back.
        single(0, 1'b1, 8'h05, 8'hA7, 8'h5F, "wr05");
        chk("mem05", 32'(mem[5]), 32'h A7);
        single(0, 1'b0, 8'h05, 8'h00, 8'hA7, "rd05");

        // Write returns old content; later read sees the new value.
        single(0, 1'b1, 8'h10, 8'h44, 8'h33, "wr10");
        single(0, 1'b0, 8'h10, 8'h00, 8'h44, "rd10");

        // Reset asserted in the ACCESS cycle of a write.
        set_cmd(0, 1'b1, 8'h20, 8'hFF);
        tick;
        chk("rstacc.mwe1", 32'(mwe), 1);
        #2 reset = 1'b1;
        #1;
        chk("rstacc.mwe0", 32'(mwe), 0);
        chk("rstacc.busy", 32'(busy), 0);
        chk("rstacc.ack",  32'(ack), 0);
        req = '0; we = '0;
        tick;
        reset = 1'b0;
        tick;
        chk("rstacc.ack2", 32'(ack), 0);
        chk("rstacc.idle", 32'(busy), 0);
        chk("rstacc.mem",  32'(mem[32]), 32'h7A);
        single(3, 1'b0, 8'h20, 8'h00, 8'h7A, "rd20");

        // Contention: all four requesters, each dropping req on its ack.
        for (int r = 0; r < N; r++) set_cmd(r, 1'b0, 8'(8'h30 + r), 8'h00);
        nack = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            chk("cont.onehot", 32'($onehot0(ack)), 1);
            if (ack != '0) begin
                chk("cont.order", 32'(ack), 32'(4'b0001 << nack));
                chk("cont.rdata", 32'(rdata), 32'(8'(8'h30 + nack) ^ 8'h5A));
                req = req & ~ack;
                nack++;
            end
        end
        chk("cont.count", nack, 4);

        // Fairness wrap: pointer at 3 after a grant to requester 2.
        single(2, 1'b0, 8'h40, 8'h00, 8'h1A, "rr2");
        set_cmd(3, 1'b0, 8'h43, 8'h00);
        set_cmd(0, 1'b0, 8'h50, 8'h00);
        tick;
        chk("wrap.g3", 32'(grant_id), 3);
        tick;
        chk("wrap.ack3", 32'(ack), 32'h8);
        chk("wrap.rd3",  32'(rdata), 32'h19);
        req[3] = 1'b0;
        tick;
        tick;
        chk("wrap.g0", 32'(grant_id), 0);
        tick;
        chk("wrap.ack0", 32'(ack), 32'h1);
        chk("wrap.rd0",  32'(rdata), 32'h0A);
        req[0] = 1'b0;
        tick;

        // Lock: requester 0 asks to keep ownership while requester 1 waits.
        single(3, 1'b0, 8'h60, 8'h00, 8'h3A, "rr3");
        set_cmd(0, 1'b0, 8'h70, 8'h00);
        set_cmd(1, 1'b0, 8'h71, 8'h00);
        lock = 4'b0001;
        tick;
        chk("lock.g0a", 32'(grant_id), 0);
        tick;
        chk("lock.ack0a", 32'(ack), 32'h1);
        tick;
        tick;
`ifdef ARB_LOCK_EN
        chk("lock.g0b", 32'(grant_id), 0);
        lock = '0;
        tick;
        chk("lock.ack0b", 32'(ack), 32'h1);
        req[0] = 1'b0;
        tick;
        tick;
        chk("lock.g1", 32'(grant_id), 1);
        tick;
        chk("lock.ack1", 32'(ack), 32'h2);
        req[1] = 1'b0;
        tick;
`else
        chk("nolock.g1", 32'(grant_id), 1);
        tick;
        chk("nolock.ack1", 32'(ack), 32'h2);
        req[1] = 1'b0;
        tick;
        tick;
        chk("nolock.g0", 32'(grant_id), 0);
        tick;
        chk("nolock.ack0", 32'(ack), 32'h1);
        req[0] = 1'b0;
        lock = '0;
        tick;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
